// File: rtl/hc_tx_port_arbiter_pkg.sv
// Shared definitions for the host-controller Tx port arbiter: state encodings,
// requester indices and the state-to-grant decode.
package hc_tx_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GNT_SOF = 3'd1,
    ST_GNT_SP  = 3'd2,
    ST_GNT_DC  = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

  localparam int REQ_SOF = 0;
  localparam int REQ_SP  = 1;
  localparam int REQ_DC  = 2;
  localparam int NUM_REQ = 3;

  // One-hot grant vector implied by an arbiter state; zero for IDLE/RELEASE.
  function automatic logic [NUM_REQ-1:0] state_gnt(arb_state_e s);
    logic [NUM_REQ-1:0] g;
    g = '0;
    case (s)
      ST_GNT_SOF: g[REQ_SOF] = 1'b1;
      ST_GNT_SP:  g[REQ_SP]  = 1'b1;
      ST_GNT_DC:  g[REQ_DC]  = 1'b1;
      default:    g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/hc_tx_port_arbiter_mux.sv
// Combinational Tx port mux: forwards only the granted requester's strobe,
// data and control; drives zeros when nothing is granted.
module hc_tx_port_mux
  import hc_tx_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] sel,
  input  logic [NUM_REQ-1:0] wen_in,
  input  logic [7:0]         data_sof,
  input  logic [7:0]         cntl_sof,
  input  logic [7:0]         data_sp,
  input  logic [7:0]         cntl_sp,
  input  logic [7:0]         data_dc,
  input  logic [7:0]         cntl_dc,
  output logic               port_wen,
  output logic [7:0]         port_data,
  output logic [7:0]         port_cntl
);

  always_comb begin
    port_wen  = 1'b0;
    port_data = 8'h00;
    port_cntl = 8'h00;
    if (sel[REQ_SOF]) begin
      port_wen  = wen_in[REQ_SOF];
      port_data = data_sof;
      port_cntl = cntl_sof;
    end else if (sel[REQ_SP]) begin
      port_wen  = wen_in[REQ_SP];
      port_data = data_sp;
      port_cntl = cntl_sp;
    end else if (sel[REQ_DC]) begin
      port_wen  = wen_in[REQ_DC];
      port_data = data_dc;
      port_cntl = cntl_dc;
    end
  end

endmodule

// File: rtl/hc_tx_port_arbiter.sv
// Fixed-priority, non-pre-emptive arbiter for the shared host-controller Tx
// port (SOF > send-packet > direct-control) with a one-cycle release gap.
module hc_tx_port_arbiter
  import hc_tx_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       SOFCntlReq,
  input  logic       SOFCntlWEn,
  input  logic [7:0] SOFCntlData,
  input  logic [7:0] SOFCntlCntl,
  input  logic       SndPktReq,
  input  logic       SndPktWEn,
  input  logic [7:0] SndPktData,
  input  logic [7:0] SndPktCntl,
  input  logic       DirCntlReq,
  input  logic       DirCntlWEn,
  input  logic [7:0] DirCntlData,
  input  logic [7:0] DirCntlCntl,
  output logic       SOFCntlGnt,
  output logic       SndPktGnt,
  output logic       DirCntlGnt,
  output logic       HCTxPortWEn,
  output logic [7:0] HCTxPortData,
  output logic [7:0] HCTxPortCntl,
  output logic       ArbBusy
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               armed_q, armed_d;
  logic [NUM_REQ-1:0] req;

  assign req = {DirCntlReq, SndPktReq, SOFCntlReq};

  // armed_q holds off arbitration for the first edge after reset release so a
  // grant can appear no earlier than the second edge.
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (armed_q) begin
          if (req[REQ_SOF])     state_d = ST_GNT_SOF;
          else if (req[REQ_SP]) state_d = ST_GNT_SP;
          else if (req[REQ_DC]) state_d = ST_GNT_DC;
        end
      end
      ST_GNT_SOF: if (!req[REQ_SOF]) state_d = ST_RELEASE;
      ST_GNT_SP:  if (!req[REQ_SP])  state_d = ST_RELEASE;
      ST_GNT_DC:  if (!req[REQ_DC])  state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    gnt_d  = state_gnt(state_d);
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign SOFCntlGnt = gnt_q[REQ_SOF];
  assign SndPktGnt  = gnt_q[REQ_SP];
  assign DirCntlGnt = gnt_q[REQ_DC];
  assign ArbBusy    = busy_q;

  hc_tx_port_mux u_mux (
    .sel      (gnt_q),
    .wen_in   ({DirCntlWEn, SndPktWEn, SOFCntlWEn}),
    .data_sof (SOFCntlData),
    .cntl_sof (SOFCntlCntl),
    .data_sp  (SndPktData),
    .cntl_sp  (SndPktCntl),
    .data_dc  (DirCntlData),
    .cntl_dc  (DirCntlCntl),
    .port_wen (HCTxPortWEn),
    .port_data(HCTxPortData),
    .port_cntl(HCTxPortCntl)
  );

endmodule

// File: tb/tb_hc_tx_port_arbiter.sv
// Self-checking bench for hc_tx_port_arbiter: table-driven scenarios, a
// mid-grant reset sequence and random traffic against a behavioural model.
module tb_hc_tx_port_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sofReq = 1'b0, sofWEn = 1'b0;
   logic       spReq = 1'b0, spWEn = 1'b0;
   logic       dcReq = 1'b0, dcWEn = 1'b0;
   logic [7:0] sofData = 8'h11, sofCntl = 8'h01;
   logic [7:0] spData = 8'hA5, spCntl = 8'h02;
   logic [7:0] dcData = 8'hFF, dcCntl = 8'h03;
   logic       sofGnt, spGnt, dcGnt, portWEn, arbBusy;
   logic [7:0] portData, portCntl;

   typedef struct {
      logic [2:0] req;
      logic [2:0] wen;
      logic [2:0] gnt;
   } vec_t;

   typedef struct {
      logic [2:0] gnt;
      logic       busy;
      logic       wen;
      logic [7:0] data;
      logic [7:0] cntl;
   } exp_t;

   exp_t sbQueue[$];
   vec_t tbl[26];
   int   checks = 0;
   int   errors = 0;
   int   mOwner = -1;
   bit   mRelease = 1'b0;

   hc_tx_port_arbiter dut (
      .clk(clk), .rst(rst),
      .SOFCntlReq(sofReq), .SOFCntlWEn(sofWEn), .SOFCntlData(sofData), .SOFCntlCntl(sofCntl),
      .SndPktReq(spReq), .SndPktWEn(spWEn), .SndPktData(spData), .SndPktCntl(spCntl),
      .DirCntlReq(dcReq), .DirCntlWEn(dcWEn), .DirCntlData(dcData), .DirCntlCntl(dcCntl),
      .SOFCntlGnt(sofGnt), .SndPktGnt(spGnt), .DirCntlGnt(dcGnt),
      .HCTxPortWEn(portWEn), .HCTxPortData(portData), .HCTxPortCntl(portCntl),
      .ArbBusy(arbBusy)
   );

   // 10 ns clock; inputs change on the falling edge, outputs sampled 1 ns after the rising edge.
   always #5 clk = ~clk;

   // Expected port/grant picture given which requester should hold the grant.
   function automatic exp_t expectFor(input logic [2:0] gnt, input logic [2:0] wen);
      exp_t e;
      e.gnt  = gnt;
      e.busy = (gnt != 3'b000);
      e.wen  = 1'b0;
      e.data = 8'h00;
      e.cntl = 8'h00;
      case (gnt)
         3'b001: begin e.wen = wen[0]; e.data = 8'h11; e.cntl = 8'h01; end
         3'b010: begin e.wen = wen[1]; e.data = 8'hA5; e.cntl = 8'h02; end
         3'b100: begin e.wen = wen[2]; e.data = 8'hFF; e.cntl = 8'h03; end
         default: ;
      endcase
      return e;
   endfunction

   // Compare the DUT's current outputs with one expected record.
   task automatic compareNow(input string name, input exp_t e);
      logic [2:0] actGnt;
      actGnt = {dcGnt, spGnt, sofGnt};
      checks++;
      if ({actGnt, arbBusy, portWEn, portData, portCntl} !== {e.gnt, e.busy, e.wen, e.data, e.cntl}) begin
         errors++;
         $display("[TB] FAIL %s: got gnt=%b busy=%b wen=%b data=%h cntl=%h, expected gnt=%b busy=%b wen=%b data=%h cntl=%h",
                  name, actGnt, arbBusy, portWEn, portData, portCntl, e.gnt, e.busy, e.wen, e.data, e.cntl);
      end
   endtask

   // Drive one cycle of requests/strobes on the falling edge and queue the expected result.
   task automatic applyStimulus(input logic [2:0] req, input logic [2:0] wen, input logic [2:0] expGnt);
      @(negedge clk);
      {dcReq, spReq, sofReq} = req;
      {dcWEn, spWEn, sofWEn} = wen;
      sbQueue.push_back(expectFor(expGnt, wen));
   endtask

   // Pop the oldest expectation and compare just after the rising edge.
   task automatic checkOutput(input string name);
      exp_t e;
      @(posedge clk);
      #1;
      if (sbQueue.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: scoreboard empty, got gnt=%b, expected an entry", name, {dcGnt, spGnt, sofGnt});
      end else begin
         e = sbQueue.pop_front();
         compareNow(name, e);
      end
   endtask

   task automatic step(input string name, input logic [2:0] req, input logic [2:0] wen, input logic [2:0] expGnt);
      applyStimulus(req, wen, expGnt);
      checkOutput(name);
   endtask

   initial begin
      logic [2:0] rReq, rWen, mGnt, actGnt;

      // Single request, arming edge, release timing.
      tbl[0]  = '{3'b010, 3'b010, 3'b000};
      tbl[1]  = '{3'b010, 3'b010, 3'b010};
      tbl[2]  = '{3'b010, 3'b010, 3'b010};
      tbl[3]  = '{3'b010, 3'b010, 3'b010};
      tbl[4]  = '{3'b010, 3'b010, 3'b010};
      tbl[5]  = '{3'b010, 3'b010, 3'b010};
      tbl[6]  = '{3'b000, 3'b000, 3'b000};
      tbl[7]  = '{3'b000, 3'b000, 3'b000};
      // All three request together: SOF, then SP after release, then DC.
      tbl[8]  = '{3'b111, 3'b111, 3'b001};
      tbl[9]  = '{3'b111, 3'b111, 3'b001};
      tbl[10] = '{3'b110, 3'b110, 3'b000};
      tbl[11] = '{3'b110, 3'b110, 3'b000};
      tbl[12] = '{3'b110, 3'b110, 3'b010};
      tbl[13] = '{3'b100, 3'b100, 3'b000};
      tbl[14] = '{3'b100, 3'b100, 3'b000};
      tbl[15] = '{3'b100, 3'b100, 3'b100};
      // DC holds despite SOF; SOF granted two cycles after DC drops.
      tbl[16] = '{3'b101, 3'b101, 3'b100};
      tbl[17] = '{3'b101, 3'b101, 3'b100};
      tbl[18] = '{3'b001, 3'b000, 3'b000};
      tbl[19] = '{3'b001, 3'b000, 3'b000};
      tbl[20] = '{3'b001, 3'b000, 3'b001};
      // DC strobing FF data while SOF owns the port must not leak.
      tbl[21] = '{3'b101, 3'b100, 3'b001};
      tbl[22] = '{3'b101, 3'b101, 3'b001};
      tbl[23] = '{3'b100, 3'b100, 3'b000};
      tbl[24] = '{3'b100, 3'b100, 3'b000};
      tbl[25] = '{3'b000, 3'b000, 3'b000};

      // Requests and strobes active during reset must not show through.
      {dcReq, spReq, sofReq} = 3'b111;
      {dcWEn, spWEn, sofWEn} = 3'b111;
      #12;
      compareNow("reset_hold", expectFor(3'b000, 3'b111));
      {dcReq, spReq, sofReq} = 3'b000;
      {dcWEn, spWEn, sofWEn} = 3'b000;
      @(posedge clk);
      #2 rst = 1'b1;

      for (int i = 0; i < 26; i++)
         step($sformatf("row%0d", i), tbl[i].req, tbl[i].wen, tbl[i].gnt);

      // Reset pulsed mid-grant drops everything without a clock edge.
      step("mr_grant", 3'b010, 3'b010, 3'b010);
      #2 rst = 1'b0;
      #1 compareNow("mr_async_drop", expectFor(3'b000, 3'b010));
      rst = 1'b1;
      step("mr_rearm", 3'b010, 3'b010, 3'b000);
      step("mr_resume", 3'b010, 3'b010, 3'b010);
      step("mr_drop", 3'b000, 3'b000, 3'b000);
      step("mr_release", 3'b000, 3'b000, 3'b000);

      // Random traffic against an owner/release model plus invariant checks.
      mOwner = -1;
      mRelease = 1'b0;
      for (int c = 0; c < 400; c++) begin
         rReq = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         rWen = 3'($urandom_range(0, 7));
         if (mRelease) mRelease = 1'b0;
         else if (mOwner >= 0) begin
            if (!rReq[mOwner]) begin
               mOwner = -1;
               mRelease = 1'b1;
            end
         end else begin
            for (int k = 0; k < 3; k++)
               if (mOwner < 0 && rReq[k]) mOwner = k;
         end
         mGnt = (mOwner >= 0) ? (3'b001 << mOwner) : 3'b000;
         applyStimulus(rReq, rWen, mGnt);
         checkOutput($sformatf("rand%0d", c));
         actGnt = {dcGnt, spGnt, sofGnt};
         checks++;
         if (!$onehot0(actGnt) || (arbBusy !== (|actGnt))) begin
            errors++;
            $display("[TB] FAIL inv%0d: got gnt=%b busy=%b, required one-hot-or-zero gnt and busy=%b",
                     c, actGnt, arbBusy, |actGnt);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
